ysyx_22050019_regfile_sb: RTL and testbench
===========================================

// Module: ysyx_22050019_regfile_sb
// PURPOSE
//  GPR file and write-back scoreboard: the receiving end of the WBU write-back port (we/waddr/wdata).
//  Holds 32x64 integer registers, with x0 hardwired to 0.
//  Provides two combinational read ports with same-cycle write-through bypass for the IDU.
//  Tracks outstanding destination writes per register so the IDU can stall on RAW hazards.
// PARAMETERS
//  XLEN    64  register width
//  NREG    32  number of architectural registers
//  AW      5   register address width
//  CNT_W   2   per-register pending-write counter width (max 3 writes in flight)
// PORTS
//  clk           in   1     core clock; all state updates on posedge
//  rst_n         in   1     asynchronous, active-low reset
//  issue_valid_i in   1     IDU issues an instruction this cycle
//  issue_we_i    in   1     issued instruction writes a GPR
//  issue_rd_i    in   AW    destination of the issued instruction
//  issue_ready_o out  1     0 = rd counter saturated; IDU must hold the issue
//  flush_i       in   1     pipeline flush; clears all pending counters
//  wb_we_i       in   1     write-back enable from WBU
//  wb_waddr_i    in   AW    write-back address
//  wb_wdata_i    in   XLEN  write-back data
//  rs1_addr_i    in   AW    read port 1 address
//  rs2_addr_i    in   AW    read port 2 address
//  rs1_data_o    out  XLEN  read port 1 data
//  rs2_data_o    out  XLEN  read port 2 data
//  rs1_busy_o    out  1     rs1 has an outstanding write not resolved this cycle
//  rs2_busy_o    out  1     rs2 has an outstanding write not resolved this cycle
//  sb_err_o      out  1     sticky: write-back arrived for a register with pending count 0
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - all GPRs <= 0, all counters <= 0, sb_err_o <= 0.
//   - Outputs during reset: data 0, busy 0, issue_ready_o 1.
//  GPR write: at posedge, if wb_we_i && wb_waddr_i!=0, then regs[wb_waddr_i] <= wb_wdata_i.
//   - Writes to x0 are discarded.
//  Reads: combinational, zero latency, independent per port.
//   - addr==0 -> 0.
//   - Else if wb_we_i && wb_waddr_i==addr -> wb_wdata_i (bypass).
//   - Else regs[addr].
//  Scoreboard: per-register counter cnt[r], r=1..NREG-1; cnt[0] is constant 0.
//   - inc(r) = issue_valid_i & issue_ready_o & issue_we_i & issue_rd_i==r & r!=0.
//   - dec(r) = wb_we_i & wb_waddr_i==r & r!=0 & cnt[r]!=0.
//   - inc & dec on the same r in one cycle -> cnt unchanged.
//   - wb_we_i to r!=0 with cnt[r]==0 -> GPR still written, no decrement, sb_err_o <= 1.
//   - sb_err_o is cleared only by reset.
//   - flush_i=1 -> all cnt <= 0 at the next edge, overriding inc/dec.
//     - The GPR write in the same cycle still happens.
//     - sb_err_o is not set by a write-back in the flush cycle.
//  Busy:
//   - rsX_busy_o = addr!=0 & cnt[addr]!=0 & !(cnt[addr]==1 & dec(addr)).
//   - The last outstanding write landing this cycle is covered by the bypass, so it is not busy.
//   - Multiple writes in flight remain busy.
//   - A same-cycle issue to the same reg does not affect busy; it counts from the next cycle.
//  issue_ready_o = !issue_we_i | issue_rd_i==0 | cnt[issue_rd_i]!=CNT_MAX.
//   - This is combinational; the same-cycle dec is not considered.
// STRUCTURE
//  Package ysyx_22050019_rf_pkg: XLEN, NREG, AW, CNT_W, CNT_MAX, REG_ZERO.
//  Sub-module ysyx_22050019_sb_cnt: one up/down counter with inc, dec, clr and is_zero/is_one/is_max.
//   - Instantiated NREG-1 times via generate.
//  Top level holds the GPR array, the read/bypass muxes, the decode of inc/dec and the sticky error flop.
// TESTING
//  1. Reset, then read x1..x31 -> all 0.
//     wb x0<=0xDEAD, read x0 -> 0, sb_err_o=0.
//  2. Issue rd=5, then wb x5<=0x1234 two cycles later:
//     - rs1=x5 busy=1 before the wb cycle.
//     - In the wb cycle: busy=0, rs1_data=0x1234 (bypass).
//     - Next cycle: 0x1234 from the array.
//  3. Issue rd=7 three times -> cnt=3, issue_ready_o=0 for rd=7, issue_ready_o=1 for rd=8.
//     - One wb x7 -> ready returns the next cycle.
//     - busy stays 1 until the third wb cycle.
//  4. Issue rd=9 and wb x9 in the same cycle with cnt[9]=1 -> cnt stays 1.
//     - rs2=x9 busy=0 that cycle, busy=1 next cycle.
//  5. Issue rd=3, rd=4; assert flush_i -> next cycle all busy=0.
//     - A later wb x3 updates the GPR and sets sb_err_o=1, which holds until rst_n=0.
//  6. Assert rst_n=0 asynchronously mid-sequence with cnt[5]=2 -> cnt, regs and sb_err_o clear without a clock edge.

Source files
------------

// File: rtl/ysyx_22050019_rf_pkg.sv
// ysyx_22050019_rf_pkg: shared widths and constants for the GPR file and its write-back scoreboard
package ysyx_22050019_rf_pkg;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW = 5;
  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [AW-1:0] REG_ZERO = '0;
endpackage

// File: rtl/ysyx_22050019_sb_cnt.sv
// ysyx_22050019_sb_cnt: per-register pending-write counter with clear and zero/one/max flags
module ysyx_22050019_sb_cnt
  import ysyx_22050019_rf_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic is_zero,
  output logic is_one,
  output logic is_max
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? '0 : (inc & ~dec) ? cnt + 1'b1 : (dec & ~inc) ? cnt - 1'b1 : cnt;
  assign is_zero = cnt == '0;
  assign is_one = cnt == CNT_W'(1);
  assign is_max = cnt == CNT_MAX;
endmodule

// File: rtl/ysyx_22050019_regfile_sb.sv
// ysyx_22050019_regfile_sb: 32x64 GPR file with write-through bypass and RAW-hazard scoreboard
module ysyx_22050019_regfile_sb
  import ysyx_22050019_rf_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid_i,
  input  logic            issue_we_i,
  input  logic [AW-1:0]   issue_rd_i,
  output logic            issue_ready_o,
  input  logic            flush_i,
  input  logic            wb_we_i,
  input  logic [AW-1:0]   wb_waddr_i,
  input  logic [XLEN-1:0] wb_wdata_i,
  input  logic [AW-1:0]   rs1_addr_i,
  input  logic [AW-1:0]   rs2_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic            rs1_busy_o,
  output logic            rs2_busy_o,
  output logic            sb_err_o
);
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] dec, is_zero, is_one, is_max;
  logic issue_fire, wb_hit;
  assign issue_fire = issue_valid_i & issue_ready_o & issue_we_i;
  assign wb_hit = wb_we_i & (wb_waddr_i != REG_ZERO);
  assign dec[0] = 1'b0;
  assign is_zero[0] = 1'b1;
  assign is_one[0] = 1'b0;
  assign is_max[0] = 1'b0;
  genvar g;
  generate
    for (g = 1; g < NREG; g++) begin : g_cnt
      logic inc;
      assign inc = issue_fire & (issue_rd_i == AW'(g));
      assign dec[g] = wb_we_i & (wb_waddr_i == AW'(g)) & ~is_zero[g];
      ysyx_22050019_sb_cnt u_cnt (
        .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec[g]), .clr(flush_i),
        .is_zero(is_zero[g]), .is_one(is_one[g]), .is_max(is_max[g])
      );
    end
  endgenerate
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_hit) begin
      regs[wb_waddr_i] <= wb_wdata_i;
    end
  // A write-back with nothing pending is a scoreboard bookkeeping error, except when a flush just discarded the counts.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sb_err_o <= 1'b0;
    else if (wb_hit & ~flush_i & is_zero[wb_waddr_i]) sb_err_o <= 1'b1;
  assign rs1_data_o = (!rst_n || rs1_addr_i == REG_ZERO) ? '0 :
                      (wb_we_i && wb_waddr_i == rs1_addr_i) ? wb_wdata_i : regs[rs1_addr_i];
  assign rs2_data_o = (!rst_n || rs2_addr_i == REG_ZERO) ? '0 :
                      (wb_we_i && wb_waddr_i == rs2_addr_i) ? wb_wdata_i : regs[rs2_addr_i];
  assign rs1_busy_o = ~is_zero[rs1_addr_i] & ~(is_one[rs1_addr_i] & dec[rs1_addr_i]);
  assign rs2_busy_o = ~is_zero[rs2_addr_i] & ~(is_one[rs2_addr_i] & dec[rs2_addr_i]);
  assign issue_ready_o = ~issue_we_i | ~is_max[issue_rd_i];
endmodule

// File: tb/tb_ysyx_22050019_regfile_sb.sv
// tb_ysyx_22050019_regfile_sb: directed and random checks against an array/integer reference model
module tb_ysyx_22050019_regfile_sb;
  logic clk = 1'b0, rst_n;
  logic issue_valid_i, issue_we_i, flush_i, wb_we_i;
  logic [4:0] issue_rd_i, wb_waddr_i, rs1_addr_i, rs2_addr_i;
  logic [63:0] wb_wdata_i, rs1_data_o, rs2_data_o;
  logic issue_ready_o, rs1_busy_o, rs2_busy_o, sb_err_o;
  logic [63:0] m_regs [32];
  int m_cnt [32];
  logic m_err;
  int n_tests = 0, n_fail = 0;

  ysyx_22050019_regfile_sb dut (
    .clk(clk), .rst_n(rst_n), .issue_valid_i(issue_valid_i), .issue_we_i(issue_we_i),
    .issue_rd_i(issue_rd_i), .issue_ready_o(issue_ready_o), .flush_i(flush_i),
    .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rs1_data_o(rs1_data_o),
    .rs2_data_o(rs2_data_o), .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o), .sb_err_o(sb_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_cnt[i] = 0;
    end
    m_err = 1'b0;
  endtask

  function automatic logic [63:0] m_read(input logic [4:0] a);
    if (a == 0) return '0;
    if (wb_we_i && wb_waddr_i == a) return wb_wdata_i;
    return m_regs[a];
  endfunction

  // Busy unless nothing pending, or the only pending write is landing right now.
  function automatic logic m_busy(input logic [4:0] a);
    if (a == 0 || m_cnt[a] == 0) return 1'b0;
    return !(m_cnt[a] == 1 && wb_we_i && wb_waddr_i == a);
  endfunction

  function automatic logic m_ready();
    return !issue_we_i || issue_rd_i == 0 || m_cnt[issue_rd_i] < 3;
  endfunction

  task automatic drive(input logic iv, input logic iwe, input logic [4:0] ird, input logic fl,
                       input logic we, input logic [4:0] wa, input logic [63:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    issue_valid_i = iv; issue_we_i = iwe; issue_rd_i = ird; flush_i = fl;
    wb_we_i = we; wb_waddr_i = wa; wb_wdata_i = wd; rs1_addr_i = r1; rs2_addr_i = r2;
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    drive(0, 0, 0, 0, 0, 0, '0, r1, r2);
  endtask

  task automatic cyc();
    logic inc, dec;
    #1;
    check("ready", issue_ready_o, m_ready());
    check("rs1_data", rs1_data_o, m_read(rs1_addr_i));
    check("rs2_data", rs2_data_o, m_read(rs2_addr_i));
    check("rs1_busy", rs1_busy_o, m_busy(rs1_addr_i));
    check("rs2_busy", rs2_busy_o, m_busy(rs2_addr_i));
    check("sb_err", sb_err_o, m_err);
    @(posedge clk);
    inc = issue_valid_i && m_ready() && issue_we_i && issue_rd_i != 0;
    dec = wb_we_i && wb_waddr_i != 0 && m_cnt[wb_waddr_i] != 0;
    if (wb_we_i && wb_waddr_i != 0) begin
      if (!flush_i && m_cnt[wb_waddr_i] == 0) m_err = 1'b1;
      m_regs[wb_waddr_i] = wb_wdata_i;
    end
    if (flush_i) for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    else begin
      if (inc) m_cnt[issue_rd_i]++;
      if (dec) m_cnt[wb_waddr_i]--;
    end
    @(negedge clk);
  endtask

  initial begin
    m_reset();
    rst_n = 1'b0;
    idle(5, 6);
    #1;
    check("rst_ready", issue_ready_o, 1'b1);
    check("rst_err", sb_err_o, 1'b0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    // x1..x31 read back zero after reset
    for (int r = 1; r < 32; r++) begin
      idle(5'(r), 5'(32 - r));
      cyc();
    end
    drive(0, 0, 0, 0, 1, 0, 64'hDEAD, 0, 0);
    #1 check("x0_bypass", rs1_data_o, 64'h0);
    cyc();
    idle(0, 0);
    #1 check("x0_err", sb_err_o, 1'b0);
    cyc();
    // issue x5, write back two cycles later
    drive(1, 1, 5, 0, 0, 0, '0, 5, 0);
    cyc();
    idle(5, 0);
    #1 check("x5_busy_pre", rs1_busy_o, 1'b1);
    cyc();
    drive(0, 0, 0, 0, 1, 5, 64'h1234, 5, 0);
    #1 check("x5_busy_wb", rs1_busy_o, 1'b0);
    check("x5_bypass", rs1_data_o, 64'h1234);
    cyc();
    idle(5, 0);
    #1 check("x5_array", rs1_data_o, 64'h1234);
    cyc();
    // saturate x7
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 7, 0, 0, 0, '0, 7, 0);
      cyc();
    end
    drive(0, 1, 7, 0, 0, 0, '0, 7, 0);
    #1 check("x7_not_ready", issue_ready_o, 1'b0);
    cyc();
    drive(0, 1, 8, 0, 0, 0, '0, 7, 0);
    #1 check("x8_ready", issue_ready_o, 1'b1);
    cyc();
    drive(0, 1, 7, 0, 1, 7, 64'h71, 7, 0);
    #1 check("x7_ready_same_dec", issue_ready_o, 1'b0);
    check("x7_busy_wb1", rs1_busy_o, 1'b1);
    cyc();
    drive(0, 1, 7, 0, 0, 0, '0, 7, 0);
    #1 check("x7_ready_after", issue_ready_o, 1'b1);
    cyc();
    drive(0, 0, 0, 0, 1, 7, 64'h72, 7, 0);
    #1 check("x7_busy_wb2", rs1_busy_o, 1'b1);
    cyc();
    drive(0, 0, 0, 0, 1, 7, 64'h73, 7, 0);
    #1 check("x7_busy_wb3", rs1_busy_o, 1'b0);
    cyc();
    // x9: issue and write-back in the same cycle with one pending
    drive(1, 1, 9, 0, 0, 0, '0, 0, 9);
    cyc();
    drive(1, 1, 9, 0, 1, 9, 64'h99, 0, 9);
    #1 check("x9_busy_same", rs2_busy_o, 1'b0);
    cyc();
    idle(0, 9);
    #1 check("x9_busy_next", rs2_busy_o, 1'b1);
    cyc();
    drive(0, 0, 0, 0, 1, 9, 64'h9A, 0, 9);
    cyc();
    // flush clears pending, later write-back flags error
    drive(1, 1, 3, 0, 0, 0, '0, 3, 4);
    cyc();
    drive(1, 1, 4, 0, 0, 0, '0, 3, 4);
    cyc();
    drive(0, 0, 0, 1, 0, 0, '0, 3, 4);
    cyc();
    idle(3, 4);
    #1 check("flush_busy1", rs1_busy_o, 1'b0);
    check("flush_busy2", rs2_busy_o, 1'b0);
    cyc();
    drive(0, 0, 0, 0, 1, 3, 64'h77, 3, 4);
    cyc();
    idle(3, 4);
    #1 check("err_set", sb_err_o, 1'b1);
    check("x3_after_flush", rs1_data_o, 64'h77);
    cyc();
    // random traffic, small address range for frequent hits
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), $urandom_range(0, 29) == 0,
            1'($urandom), 5'($urandom_range(0, 7)), {$urandom, $urandom},
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      cyc();
    end
    // async reset with two writes pending on x5
    drive(0, 0, 0, 1, 1, 6, 64'h66, 0, 0);
    cyc();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 5, 0, 0, 0, '0, 5, 6);
      cyc();
    end
    drive(0, 1, 5, 0, 0, 0, '0, 5, 6);
    #1 check("pre_rst_busy", rs1_busy_o, 1'b1);
    check("pre_rst_data", rs2_data_o, 64'h66);
    #1 rst_n = 1'b0;
    #1;
    check("async_busy", rs1_busy_o, 1'b0);
    check("async_data", rs2_data_o, 64'h0);
    check("async_err", sb_err_o, 1'b0);
    check("async_ready", issue_ready_o, 1'b1);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(5'(5 + i % 2), 6);
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
